// File: rtl/npu_multi_channel_logger.sv
// N-channel event logger: filtered events go into per-channel circular logs, and a snoop port reads them back.
// Define NPU_LOGGER_TIMESTAMP_EN to store a free-running cycle timestamp with every record.
`timescale 1ns/1ps
`ifndef IO_MAP_BASE_ADDR
`define IO_MAP_BASE_ADDR 32'hFF00_0000
`endif

module npu_multi_channel_logger #(
  parameter int NUM_CH = 4,
  parameter int DEPTH = 512,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] FILTER_BASE = `IO_MAP_BASE_ADDR,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         clear_i,
  input  logic [NUM_CH-1:0]            ev_valid_i,
  input  logic [NUM_CH-1:0]            ev_is_write_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ev_addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ev_data_i,
  input  logic                         snoop_valid_i,
  output logic                         snoop_ready_o,
  input  logic [1:0]                   snoop_cmd_i,
  input  logic [CHW-1:0]               snoop_ch_i,
  input  logic [IW-1:0]                snoop_idx_i,
  output logic                         lg_valid_o,
  input  logic                         lg_ready_i,
  output logic [ADDR_WIDTH-1:0]        lg_addr_o,
  output logic [DATA_WIDTH-1:0]        lg_data_o,
  output logic [ADDR_WIDTH-1:0]        lg_id_o,
  output logic                         lg_is_write_o,
  output logic                         lg_is_read_o,
  output logic                         lg_err_o,
  output logic [NUM_CH-1:0]            lg_overflow_o,
  output logic [ADDR_WIDTH-1:0]        lg_ts_o
);

  localparam logic [1:0] CMD_READ   = 2'd0;
  localparam logic [1:0] CMD_COUNT  = 2'd1;
  localparam logic [1:0] CMD_GLOBAL = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_RESP} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           wr_ptr [NUM_CH];
  logic [CW-1:0]           count  [NUM_CH];
  logic [NUM_CH-1:0]       overflow;
  logic [ADDR_WIDTH-1:0]   global_cnt, global_nxt;
  logic [NUM_CH-1:0]       logged;
  logic [ADDR_WIDTH-1:0]   ev_id [NUM_CH];

  logic [ADDR_WIDTH-1:0]   mem_addr [NUM_CH][DEPTH];
  logic [DATA_WIDTH-1:0]   mem_data [NUM_CH][DEPTH];
  logic [ADDR_WIDTH-1:0]   mem_id   [NUM_CH][DEPTH];
  logic                    mem_wr   [NUM_CH][DEPTH];
`ifdef NPU_LOGGER_TIMESTAMP_EN
  logic [ADDR_WIDTH-1:0]   mem_ts   [NUM_CH][DEPTH];
  logic [ADDR_WIDTH-1:0]   ts_cnt;
`endif

  logic [1:0]              cmd_q;
  logic [CHW-1:0]          ch_q;
  logic [IW-1:0]           idx_q;

  logic                    ch_ok;
  logic [CHW-1:0]          ch_sel;
  logic [IW-1:0]           phys;
  logic [ADDR_WIDTH-1:0]   rd_addr, rd_id, rd_ts;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_wr, rd_isr, rd_err;

  // Capture stage: filter, then hand out IDs in channel order within the cycle
  always_comb begin
    logic [ADDR_WIDTH-1:0] run;
    run = global_cnt;
    logged = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ev_id[c] = run;
      if (enable && !clear_i && ev_valid_i[c] &&
          ev_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH] >= FILTER_BASE) begin
        logged[c] = 1'b1;
        run = run + ADDR_WIDTH'(1);
      end
    end
    global_nxt = run;
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (logged[c]) begin
        mem_addr[c][wr_ptr[c]] <= ev_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
        mem_data[c][wr_ptr[c]] <= ev_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        mem_id[c][wr_ptr[c]]   <= ev_id[c];
        mem_wr[c][wr_ptr[c]]   <= ev_is_write_i[c];
`ifdef NPU_LOGGER_TIMESTAMP_EN
        mem_ts[c][wr_ptr[c]]   <= ts_cnt;
`endif
      end
    end
  end

  // A full log keeps its count at DEPTH; the write pointer then also marks the oldest entry
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end
      overflow   <= '0;
      global_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (logged[c]) begin
          wr_ptr[c] <= wr_ptr[c] + IW'(1);
          if (count[c] == CW'(DEPTH))
            overflow[c] <= 1'b1;
          else
            count[c] <= count[c] + CW'(1);
        end
      end
      global_cnt <= global_nxt;
    end
  end

`ifdef NPU_LOGGER_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (reset)
      ts_cnt <= '0;
    else
      ts_cnt <= ts_cnt + ADDR_WIDTH'(1);
  end
`endif

  // Snoop control
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (snoop_valid_i) state_nxt = S_RD;
      S_RD:    state_nxt = S_RESP;
      S_RESP:  if (lg_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign snoop_ready_o = (state == S_IDLE);
  assign lg_valid_o    = (state == S_RESP);
  assign lg_overflow_o = overflow;

  always_ff @(posedge clk) begin
    if (state == S_IDLE && snoop_valid_i) begin
      cmd_q <= snoop_cmd_i;
      ch_q  <= snoop_ch_i;
      idx_q <= snoop_idx_i;
    end
  end

  // Read stage: idx counts from the oldest held record; same-cycle writes to the slot win
  always_comb begin
    ch_ok   = (int'(ch_q) < NUM_CH);
    ch_sel  = ch_ok ? ch_q : '0;
    phys    = wr_ptr[ch_sel] - count[ch_sel][IW-1:0] + idx_q;
    rd_addr = '0;
    rd_data = '0;
    rd_id   = '0;
    rd_ts   = '0;
    rd_wr   = 1'b0;
    rd_isr  = 1'b0;
    rd_err  = 1'b0;
    case (cmd_q)
      CMD_READ: begin
        if (!ch_ok || {1'b0, idx_q} >= count[ch_sel]) begin
          rd_err = 1'b1;
        end else if (logged[ch_sel] && wr_ptr[ch_sel] == phys) begin
          rd_addr = ev_addr_i[ch_sel*ADDR_WIDTH +: ADDR_WIDTH];
          rd_data = ev_data_i[ch_sel*DATA_WIDTH +: DATA_WIDTH];
          rd_id   = ev_id[ch_sel];
          rd_wr   = ev_is_write_i[ch_sel];
          rd_isr  = !ev_is_write_i[ch_sel];
`ifdef NPU_LOGGER_TIMESTAMP_EN
          rd_ts   = ts_cnt;
`endif
        end else begin
          rd_addr = mem_addr[ch_sel][phys];
          rd_data = mem_data[ch_sel][phys];
          rd_id   = mem_id[ch_sel][phys];
          rd_wr   = mem_wr[ch_sel][phys];
          rd_isr  = !mem_wr[ch_sel][phys];
`ifdef NPU_LOGGER_TIMESTAMP_EN
          rd_ts   = mem_ts[ch_sel][phys];
`endif
        end
      end
      CMD_COUNT: begin
        if (!ch_ok)
          rd_err = 1'b1;
        else
          rd_id = ADDR_WIDTH'(count[ch_sel]);
      end
      CMD_GLOBAL: rd_id = global_cnt;
      default:    rd_id = ADDR_WIDTH'(overflow);
    endcase
  end

  // Response stage: registered once at the end of RD, held until consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      lg_addr_o     <= '0;
      lg_data_o     <= '0;
      lg_id_o       <= '0;
      lg_is_write_o <= 1'b0;
      lg_is_read_o  <= 1'b0;
      lg_err_o      <= 1'b0;
    end else if (state == S_RD) begin
      lg_addr_o     <= rd_addr;
      lg_data_o     <= rd_data;
      lg_id_o       <= rd_id;
      lg_is_write_o <= rd_wr;
      lg_is_read_o  <= rd_isr;
      lg_err_o      <= rd_err;
    end
  end

`ifdef NPU_LOGGER_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (reset)
      lg_ts_o <= '0;
    else if (state == S_RD)
      lg_ts_o <= rd_ts;
  end
`else
  assign lg_ts_o = '0;
`endif

endmodule

// File: tb/tb_npu_multi_channel_logger.sv
// Scoreboard bench for npu_multi_channel_logger: queue-based log model, randomized and directed traffic.
`timescale 1ns/1ps
module tb_npu_multi_channel_logger;
  localparam int NCH = 4;
  localparam int DEP = 8;
  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int IW  = 3;
  localparam int CHW = 2;
  localparam logic [AW-1:0] FB = 32'hFF00_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, enable, clear_i;
  logic [NCH-1:0]  ev_valid_i, ev_is_write_i;
  logic [NCH*AW-1:0] ev_addr_i;
  logic [NCH*DW-1:0] ev_data_i;
  logic            snoop_valid_i, snoop_ready_o;
  logic [1:0]      snoop_cmd_i;
  logic [CHW-1:0]  snoop_ch_i;
  logic [IW-1:0]   snoop_idx_i;
  logic            lg_valid_o, lg_ready_i;
  logic [AW-1:0]   lg_addr_o, lg_id_o, lg_ts_o;
  logic [DW-1:0]   lg_data_o;
  logic            lg_is_write_o, lg_is_read_o, lg_err_o;
  logic [NCH-1:0]  lg_overflow_o;

  npu_multi_channel_logger #(
    .NUM_CH(NCH), .DEPTH(DEP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FILTER_BASE(FB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_i(clear_i),
    .ev_valid_i(ev_valid_i), .ev_is_write_i(ev_is_write_i),
    .ev_addr_i(ev_addr_i), .ev_data_i(ev_data_i),
    .snoop_valid_i(snoop_valid_i), .snoop_ready_o(snoop_ready_o),
    .snoop_cmd_i(snoop_cmd_i), .snoop_ch_i(snoop_ch_i), .snoop_idx_i(snoop_idx_i),
    .lg_valid_o(lg_valid_o), .lg_ready_i(lg_ready_i),
    .lg_addr_o(lg_addr_o), .lg_data_o(lg_data_o), .lg_id_o(lg_id_o),
    .lg_is_write_o(lg_is_write_o), .lg_is_read_o(lg_is_read_o), .lg_err_o(lg_err_o),
    .lg_overflow_o(lg_overflow_o), .lg_ts_o(lg_ts_o)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wr;
    logic [AW-1:0] id;
    logic [AW-1:0] ts;
  } rec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] id;
    logic          wr;
    logic          rd;
    logic          err;
    logic [AW-1:0] ts;
  } exp_t;

  rec_t logq [NCH][$];
  exp_t sb [$];
  logic [NCH-1:0] m_ovf;
  logic [AW-1:0]  m_glob, m_ts;
  int phase;
  logic [1:0] q_cmd;
  int q_ch, q_idx;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic rec_t mk(input int c, input logic [AW-1:0] id);
    rec_t r;
    r.addr = ev_addr_i[c*AW +: AW];
    r.data = ev_data_i[c*DW +: DW];
    r.wr   = ev_is_write_i[c];
    r.id   = id;
`ifdef NPU_LOGGER_TIMESTAMP_EN
    r.ts   = m_ts;
`else
    r.ts   = '0;
`endif
    return r;
  endfunction

  // Applies the current cycle's inputs to the model, then advances to the next cycle
  task automatic step();
    logic [NCH-1:0] lg;
    logic [AW-1:0]  ids [NCH];
    logic [AW-1:0]  run;
    rec_t r;
    exp_t e;
    chk("snoop_ready", snoop_ready_o, phase == 0);
    chk("lg_valid", lg_valid_o, phase == 2);
    chk("overflow", lg_overflow_o, m_ovf);
    if (reset) begin
      for (int c = 0; c < NCH; c++) logq[c].delete();
      m_ovf = '0; m_glob = '0; m_ts = '0; phase = 0;
      sb.delete();
    end else begin
      run = m_glob;
      for (int c = 0; c < NCH; c++) begin
        ids[c] = run;
        lg[c] = enable && !clear_i && ev_valid_i[c] && (ev_addr_i[c*AW +: AW] >= FB);
        if (lg[c]) run = run + 1;
      end
      if (phase == 1) begin
        e.addr = '0; e.data = '0; e.id = '0; e.wr = 0; e.rd = 0; e.err = 0; e.ts = '0;
        case (q_cmd)
          2'd0: begin
            if (q_idx >= logq[q_ch].size()) e.err = 1;
            else begin
              if (logq[q_ch].size() == DEP && lg[q_ch] && q_idx == 0) r = mk(q_ch, ids[q_ch]);
              else r = logq[q_ch][q_idx];
              e.addr = r.addr; e.data = r.data; e.id = r.id;
              e.wr = r.wr; e.rd = !r.wr; e.ts = r.ts;
            end
          end
          2'd1: e.id = logq[q_ch].size();
          2'd2: e.id = m_glob;
          default: e.id = AW'(m_ovf);
        endcase
        sb.push_back(e);
      end
      if (phase == 0 && snoop_valid_i) begin
        phase = 1; q_cmd = snoop_cmd_i; q_ch = int'(snoop_ch_i); q_idx = int'(snoop_idx_i);
      end else if (phase == 1) phase = 2;
      else if (phase == 2 && lg_ready_i) phase = 0;
      if (clear_i) begin
        for (int c = 0; c < NCH; c++) logq[c].delete();
        m_ovf = '0; m_glob = '0;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (lg[c]) begin
            if (logq[c].size() == DEP) begin
              logq[c].delete(0);
              m_ovf[c] = 1'b1;
            end
            logq[c].push_back(mk(c, ids[c]));
          end
        end
        m_glob = run;
      end
      m_ts = m_ts + 1;
    end
    @(posedge clk); #2;
  endtask

  task automatic idle_ev();
    ev_valid_i = '0;
  endtask

  task automatic ev(input int c, input logic [AW-1:0] a, input logic w);
    ev_valid_i[c] = 1'b1;
    ev_is_write_i[c] = w;
    ev_addr_i[c*AW +: AW] = a;
    ev_data_i[c*DW +: DW] = {$urandom, $urandom};
  endtask

  task automatic snoop(input logic [1:0] cmd, input int ch, input int idx, input int hold, input bit rd_ev);
    int n;
    n = 0;
    while (phase != 0 && n < 50) begin step(); n++; end
    snoop_valid_i = 1'b1; snoop_cmd_i = cmd;
    snoop_ch_i = CHW'(ch); snoop_idx_i = IW'(idx);
    step();
    snoop_valid_i = 1'b0;
    if (rd_ev) ev(ch, FB + 32'h40, $urandom_range(0, 1));
    step();
    idle_ev();
    lg_ready_i = (hold == 0);
    for (int h = 0; h < hold; h++) step();
    lg_ready_i = 1'b1;
    step();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && lg_valid_o) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_response actual=valid required=none");
        end else begin
          chk("resp_addr", lg_addr_o, sb[0].addr);
          chk("resp_data", lg_data_o, sb[0].data);
          chk("resp_id", lg_id_o, sb[0].id);
          chk("resp_is_write", lg_is_write_o, sb[0].wr);
          chk("resp_is_read", lg_is_read_o, sb[0].rd);
          chk("resp_err", lg_err_o, sb[0].err);
          chk("resp_ts", lg_ts_o, sb[0].ts);
          if (lg_ready_i) sb.delete(0);
        end
      end
    end
  end

  initial begin
    reset = 1; enable = 1; clear_i = 0;
    ev_valid_i = '0; ev_is_write_i = '0; ev_addr_i = '0; ev_data_i = '0;
    snoop_valid_i = 0; snoop_cmd_i = '0; snoop_ch_i = '0; snoop_idx_i = '0; lg_ready_i = 1;
    phase = 0; m_ovf = '0; m_glob = '0; m_ts = '0;
    @(posedge clk); #2;
    step(); step();
    reset = 0;
    chk("reset_addr", lg_addr_o, 0);
    chk("reset_data", lg_data_o, 0);
    chk("reset_id", lg_id_o, 0);
    chk("reset_err", lg_err_o, 0);
    chk("reset_flags", {lg_is_write_o, lg_is_read_o}, 0);
    chk("reset_ts", lg_ts_o, 0);

    // two single events, then read the second back
    ev(0, 32'hFF00_0010, 1'b1); step(); idle_ev();
    ev(1, 32'hFF00_0020, 1'b0); step(); idle_ev();
    snoop(2'd0, 1, 0, 0, 0);

    // bring global count to 5, then all channels in one cycle
    for (int i = 0; i < 3; i++) begin ev(0, FB + 32'h100, 1'b1); step(); idle_ev(); end
    for (int c = 0; c < NCH; c++) ev(c, FB + 32'(c * 16), 1'b1);
    step(); idle_ev();
    snoop(2'd0, 0, 4, 0, 0);
    snoop(2'd0, 1, 1, 0, 0);
    snoop(2'd0, 2, 0, 0, 0);
    snoop(2'd0, 3, 0, 0, 0);
    snoop(2'd2, 0, 0, 0, 0);

    // wrap channel 2
    clear_i = 1; step(); clear_i = 0;
    for (int i = 0; i < 10; i++) begin ev(2, FB + 32'(i * 4), i[0]); step(); idle_ev(); end
    snoop(2'd1, 2, 0, 0, 0);
    snoop(2'd3, 0, 0, 0, 0);
    snoop(2'd0, 2, 0, 0, 0);
    snoop(2'd0, 2, 7, 0, 0);
    snoop(2'd0, 2, 0, 0, 1);

    // filter boundary
    clear_i = 1; step(); clear_i = 0;
    ev(0, 32'h0000_1000, 1'b1); step(); idle_ev();
    snoop(2'd1, 0, 0, 0, 0);
    snoop(2'd0, 0, 0, 0, 0);
    ev(1, FB - 1, 1'b1); ev(2, FB, 1'b0); step(); idle_ev();
    snoop(2'd1, 1, 0, 0, 0);
    snoop(2'd0, 2, 0, 0, 0);

    // back-pressure then an immediate follow-up command
    snoop(2'd2, 0, 0, 5, 0);
    snoop(2'd1, 2, 0, 0, 0);

    // clear wins over a coincident event
    for (int i = 0; i < 9; i++) begin ev(1, FB + 32'h8, 1'b1); step(); idle_ev(); end
    ev(3, FB + 32'h30, 1'b1); clear_i = 1; step(); clear_i = 0; idle_ev();
    snoop(2'd1, 3, 0, 0, 0);
    snoop(2'd2, 0, 0, 0, 0);
    snoop(2'd3, 0, 0, 0, 0);

    // logging disabled
    enable = 0;
    ev(0, FB + 32'h4, 1'b1); ev(3, FB + 32'h4, 1'b0); step(); step(); idle_ev();
    snoop(2'd1, 0, 0, 0, 0);
    enable = 1;
    ev(0, FB + 32'h4, 1'b1); step(); idle_ev(); step(); step();
    ev(0, FB + 32'h8, 1'b0); step(); idle_ev();
    snoop(2'd0, 0, 0, 0, 0);
    snoop(2'd0, 0, 1, 0, 0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NCH; c++) begin
        int r;
        logic [AW-1:0] a;
        r = $urandom_range(0, 9);
        case (r)
          0: a = FB - 1;
          1: a = FB;
          2: a = $urandom_range(0, 32'h7FFF_FFFF);
          3: a = 32'hFFFF_FFFF;
          default: a = FB + $urandom_range(0, 4095);
        endcase
        ev_valid_i[c] = ($urandom_range(0, 2) != 0);
        ev_is_write_i[c] = $urandom_range(0, 1);
        ev_addr_i[c*AW +: AW] = a;
        ev_data_i[c*DW +: DW] = {$urandom, $urandom};
      end
      enable = ($urandom_range(0, 19) != 0);
      clear_i = ($urandom_range(0, 59) == 0);
      snoop_valid_i = $urandom_range(0, 1);
      snoop_cmd_i = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      snoop_ch_i = CHW'($urandom_range(0, NCH - 1));
      snoop_idx_i = IW'($urandom_range(0, DEP - 1));
      lg_ready_i = ($urandom_range(0, 9) < 7);
      step();
    end
    idle_ev(); clear_i = 0; enable = 1; snoop_valid_i = 0; lg_ready_i = 1;
    for (int n = 0; n < 6; n++) step();

    // reset while a response is pending
    lg_ready_i = 0; snoop_valid_i = 1; snoop_cmd_i = 2'd2;
    step(); snoop_valid_i = 0;
    step(); step();
    reset = 1; step(); reset = 0;
    chk("midreset_id", lg_id_o, 0);
    chk("midreset_err", lg_err_o, 0);
    lg_ready_i = 1;
    step();
    snoop(2'd1, 0, 0, 0, 0);

    for (int n = 0; n < 10 && sb.size() != 0; n++) step();
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
